cp0_exc_sequencer: RTL

Commit-point exception/interrupt sequencer that sits between the WB stage and the CP0 register file. Each cycle it decides whether the committing instruction retires normally, takes an exception or interrupt, or executes ERET. It then drives a fixed flush → redirect sequence: a one-cycle CP0 update strobe, a pipeline flush, and a fetch redirect with a valid/ready handshake. WB commit is stalled until the sequence completes.

---
 rtl/cp0_exc_sequencer_if.sv | 46 ++++
 rtl/cp0_exc_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/cp0_exc_sequencer_if.sv
// Commit-point bus between WB, CP0 and fetch, as seen by the exception sequencer.
// The master modport is the pipeline/CP0 environment; the slave modport is the sequencer.
interface cp0_exc_sequencer_if;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_exc;
  logic [4:0]  wb_exc_code;
  logic        wb_bd;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        wb_eret;
  logic        wb_mtc0;
  logic [5:0]  hw_int;
  logic [7:0]  cause_ip;
  logic [7:0]  status_im;
  logic        status_ie;
  logic        status_exl;
  logic [31:0] cp0_epc;
  logic [5:0]  hw_int_sync;
  logic        mtc0_we;
  logic        exc_we;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic        badvaddr_we;
  logic        eret_we;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output wb_valid, wb_exc, wb_exc_code, wb_bd, wb_pc, wb_badvaddr, wb_eret, wb_mtc0,
    output hw_int, cause_ip, status_im, status_ie, status_exl, cp0_epc, redirect_ready,
    input  wb_ready, hw_int_sync, mtc0_we, exc_we, exc_code, exc_bd, exc_epc, exc_badvaddr,
    input  badvaddr_we, eret_we, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  wb_valid, wb_exc, wb_exc_code, wb_bd, wb_pc, wb_badvaddr, wb_eret, wb_mtc0,
    input  hw_int, cause_ip, status_im, status_ie, status_exl, cp0_epc, redirect_ready,
    output wb_ready, hw_int_sync, mtc0_we, exc_we, exc_code, exc_bd, exc_epc, exc_badvaddr,
    output badvaddr_we, eret_we, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cp0_exc_sequencer.sv
// Commit-point exception/interrupt/ERET sequencer: decides at WB, then runs a fixed
// CP0-update -> flush -> fetch-redirect sequence while stalling WB.
module cp0_exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR  = 32'hbfc00380,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst_n,
  cp0_exc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFlush, StRedirect} state_e;

  state_e      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] bva_q, bva_d;
  logic [31:0] target_q, target_d;
  logic        eret_kind_q, eret_kind_d;

  logic [SYNC_STAGES-1:0][5:0] sync_q;

  logic int_pending;
  logic take_int, take_exc, take_eret, take_event;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.hw_int};
    end
  end

  assign bus.hw_int_sync = sync_q[SYNC_STAGES-1];

  assign int_pending = (|(bus.cause_ip & bus.status_im)) & bus.status_ie & ~bus.status_exl;

  // Priority: interrupt, then pipeline exception, then ERET.
  assign take_int   = bus.wb_valid & int_pending;
  assign take_exc   = bus.wb_valid & ~int_pending & bus.wb_exc;
  assign take_eret  = bus.wb_valid & ~int_pending & ~bus.wb_exc & bus.wb_eret;
  assign take_event = (state_q == StIdle) & (take_int | take_exc | take_eret);

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    bd_d        = bd_q;
    epc_d       = epc_q;
    bva_d       = bva_q;
    target_d    = target_q;
    eret_kind_d = eret_kind_q;

    unique case (state_q)
      StIdle: begin
        if (take_event) begin
          state_d     = StFlush;
          eret_kind_d = take_eret;
          if (take_eret) begin
            target_d = bus.cp0_epc;
          end else begin
            target_d = EXC_VECTOR;
            code_d   = take_int ? 5'd0 : bus.wb_exc_code;
            bd_d     = bus.wb_bd;
            epc_d    = bus.wb_bd ? (bus.wb_pc - 32'd4) : bus.wb_pc;
            bva_d    = bus.wb_badvaddr;
          end
        end
      end
      StFlush: begin
        state_d = StRedirect;
      end
      StRedirect: begin
        if (bus.redirect_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      code_q      <= '0;
      bd_q        <= 1'b0;
      epc_q       <= '0;
      bva_q       <= '0;
      target_q    <= '0;
      eret_kind_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      bd_q        <= bd_d;
      epc_q       <= epc_d;
      bva_q       <= bva_d;
      target_q    <= target_d;
      eret_kind_q <= eret_kind_d;
    end
  end

  // Combinational outputs are gated by rst_n so every output reads 0 while reset is held.
  assign bus.wb_ready = rst_n & (state_q == StIdle);
  assign bus.mtc0_we  = rst_n & (state_q == StIdle) & bus.wb_valid & bus.wb_mtc0 & ~take_event;

  assign bus.exc_we         = (state_q == StFlush) & ~eret_kind_q;
  assign bus.eret_we        = (state_q == StFlush) & eret_kind_q;
  assign bus.badvaddr_we    = bus.exc_we & ((code_q == 5'd4) | (code_q == 5'd5));
  assign bus.flush          = (state_q == StFlush) | (state_q == StRedirect);
  assign bus.redirect_valid = (state_q == StRedirect);
  assign bus.redirect_pc    = target_q;
  assign bus.exc_code       = code_q;
  assign bus.exc_bd         = bd_q;
  assign bus.exc_epc        = epc_q;
  assign bus.exc_badvaddr   = bva_q;

endmodule
